// File: rtl/cmp_share_arb.sv
// rtl/cmp_share_arb.sv - round-robin arbiter sequencing two requesters onto one set-less-than comparator
module cmp_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sgn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sgn,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_o,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             winner;
  logic             lt;
  logic             idle;

  // On a tie the requester that was not served last wins; reset value 1 favours req0.
  assign winner = req1_valid && (!req0_valid || !last_grant);
  assign idle   = (state == IDLE);

  assign req0_ready = idle && req0_valid && !winner;
  assign req1_ready = idle && req1_valid && winner;
  assign busy       = !idle;

  assign lt = (sgn_q && (a_q[WIDTH-1] != b_q[WIDTH-1])) ? a_q[WIDTH-1] : (a_q < b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      resp_o      <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            owner      <= winner;
            last_grant <= winner;
            a_q        <= winner ? req1_a   : req0_a;
            b_q        <= winner ? req1_b   : req0_b;
            sgn_q      <= winner ? req1_sgn : req0_sgn;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_o      <= {{(WIDTH-1){1'b0}}, lt};
          resp0_valid <= !owner;
          resp1_valid <= owner;
          state       <= RESP;
        end
        RESP: begin
          if (owner ? resp1_ready : resp0_ready) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
